clk_freq_meter: RTL and testbench

CLK_FREQ_METER -- requirements
Module: clk_freq_meter

---
 rtl/clk_freq_meter.sv | 128 ++++++++++++
 tb/tb_clk_freq_meter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// Gated frequency counter: counts rising edges of an asynchronous input over a
// fixed window of GATE_CYCLES clk cycles and reports the count once per window.
module clk_freq_meter #(
  parameter int GATE_CYCLES = 40000,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             enable,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic             no_signal
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, LATCH} state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             hist_q, hist_d;
  logic [GW-1:0]    gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic [CNT_W-1:0] freq_q, freq_d;
  logic             freq_valid_q, freq_valid_d;
  logic             overflow_q, overflow_d;
  logic             no_signal_q, no_signal_d;

  logic             rise;
  logic [CNT_W-1:0] cnt_inc;
  logic             flag_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      hist_q       <= 1'b0;
      gate_cnt_q   <= '0;
      edge_cnt_q   <= '0;
      ovf_flag_q   <= 1'b0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      no_signal_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      gate_cnt_q   <= gate_cnt_d;
      edge_cnt_q   <= edge_cnt_d;
      ovf_flag_q   <= ovf_flag_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      overflow_q   <= overflow_d;
      no_signal_q  <= no_signal_d;
    end
  end

  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
    hist_d  = sync2_q;
    rise    = sync2_q & ~hist_q;

    // Saturating edge count including this cycle's edge
    cnt_inc  = edge_cnt_q;
    flag_inc = ovf_flag_q;
    if (rise) begin
      if (edge_cnt_q == CNT_MAX) begin
        flag_inc = 1'b1;
      end else begin
        cnt_inc = edge_cnt_q + 1'b1;
      end
    end

    state_d      = state_q;
    gate_cnt_d   = '0;
    edge_cnt_d   = '0;
    ovf_flag_d   = 1'b0;
    freq_d       = freq_q;
    overflow_d   = overflow_q;
    no_signal_d  = no_signal_q;
    freq_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) state_d = GATE;
      end
      GATE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (gate_cnt_q == GATE_LAST) begin
          // Results are loaded on entry so they are already visible while
          // the LATCH cycle presents the freq_valid pulse.
          state_d      = LATCH;
          freq_d       = cnt_inc;
          overflow_d   = flag_inc;
          no_signal_d  = (cnt_inc == '0);
          freq_valid_d = 1'b1;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
          edge_cnt_d = cnt_inc;
          ovf_flag_d = flag_inc;
        end
      end
      LATCH: begin
        state_d = enable ? GATE : IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;
  assign no_signal  = no_signal_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: table of steady-signal windows plus
// hand-timed sequences for boundary edges, abort, reset and overflow.
module tb_clk_freq_meter;

  localparam int GATE = 400;

  logic       clk;
  logic       rst_a, en_a, man_mode_a, man_sig_a, gen_sig_a, sig_a;
  logic       rst_b, en_b, gen_sig_b;
  logic [15:0] freq_a;
  logic       fv_a, ovf_a, nosig_a;
  logic [3:0] freq_b;
  logic       fv_b, ovf_b, nosig_b;
  int         per_a, per_b;
  int         total, bad;

  typedef struct {
    int period;
    int exp_freq;
    bit exp_ovf;
    bit exp_nosig;
  } vec_t;
  vec_t vecs[6];

  assign sig_a = man_mode_a ? man_sig_a : gen_sig_a;

  clk_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst_a), .sig_in(sig_a), .enable(en_a),
    .freq(freq_a), .freq_valid(fv_a), .overflow(ovf_a), .no_signal(nosig_a)
  );

  clk_freq_meter #(.GATE_CYCLES(GATE), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst_b), .sig_in(gen_sig_b), .enable(en_b),
    .freq(freq_b), .freq_valid(fv_b), .overflow(ovf_b), .no_signal(nosig_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin : gen_a_proc
    int ph;
    ph = 0;
    gen_sig_a = 1'b0;
    forever begin
      @(negedge clk);
      if (per_a < 2) begin
        gen_sig_a = 1'b0;
        ph = 0;
      end else begin
        if (ph >= per_a) ph = 0;
        gen_sig_a = (ph < per_a / 2);
        ph++;
      end
    end
  end

  initial begin : gen_b_proc
    int ph;
    ph = 0;
    gen_sig_b = 1'b0;
    forever begin
      @(negedge clk);
      if (per_b < 2) begin
        gen_sig_b = 1'b0;
        ph = 0;
      end else begin
        if (ph >= per_b) ph = 0;
        gen_sig_b = (ph < per_b / 2);
        ph++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  task automatic wait_valid(input bit sel, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 1000) begin
      @(negedge clk);
      n++;
      if ((sel ? fv_b : fv_a) == 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL wait_valid: no freq_valid within %0d cycles, required one", n);
    end
  endtask

  initial begin
    int n;
    int pulses;
    total = 0; bad = 0;
    rst_a = 1'b1; rst_b = 1'b1;
    en_a = 1'b0; en_b = 1'b0;
    man_mode_a = 1'b0; man_sig_a = 1'b0;
    per_a = 40; per_b = 4;

    vecs[0] = '{40, 10, 1'b0, 1'b0};
    vecs[1] = '{20, 20, 1'b0, 1'b0};
    vecs[2] = '{8,  50, 1'b0, 1'b0};
    vecs[3] = '{100, 4, 1'b0, 1'b0};
    vecs[4] = '{0,   0, 1'b0, 1'b1};
    vecs[5] = '{10, 40, 1'b0, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_freq", freq_a, 0);
    chk("reset_valid", fv_a, 0);
    chk("reset_overflow", ovf_a, 0);
    chk("reset_no_signal", nosig_a, 0);
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (100) @(negedge clk);

    // First window latency and result
    en_a = 1'b1;
    wait_valid(0, n);
    chk("first_latency", n, GATE + 1);
    chk("first_freq", freq_a, 10);
    chk("first_overflow", ovf_a, 0);
    chk("first_no_signal", nosig_a, 0);
    @(negedge clk);
    chk("valid_one_cycle", fv_a, 0);

    // Steady-signal windows; the first window after a change is settling
    for (int i = 0; i < 6; i++) begin
      per_a = vecs[i].period;
      wait_valid(0, n);
      wait_valid(0, n);
      chk($sformatf("vec%0d_interval", i), n, GATE + 1);
      chk($sformatf("vec%0d_freq", i), freq_a, vecs[i].exp_freq);
      chk($sformatf("vec%0d_overflow", i), ovf_a, vecs[i].exp_ovf);
      chk($sformatf("vec%0d_no_signal", i), nosig_a, vecs[i].exp_nosig);
    end

    // Edge detected in the last gate cycle is counted
    man_mode_a = 1'b1; man_sig_a = 1'b0;
    wait_valid(0, n);
    repeat (GATE - 2) @(negedge clk);
    man_sig_a = 1'b1;
    @(negedge clk);
    man_sig_a = 1'b0;
    wait_valid(0, n);
    chk("edge_last_gate_freq", freq_a, 1);
    chk("edge_last_gate_no_signal", nosig_a, 0);
    // Edge detected in the LATCH cycle is dropped
    repeat (GATE - 1) @(negedge clk);
    man_sig_a = 1'b1;
    @(negedge clk);
    man_sig_a = 1'b0;
    wait_valid(0, n);
    chk("edge_in_latch_freq", freq_a, 0);
    chk("edge_in_latch_no_signal", nosig_a, 1);
    wait_valid(0, n);
    chk("edge_not_carried_freq", freq_a, 0);
    chk("edge_not_carried_interval", n, GATE + 1);

    // Abort mid-window
    man_mode_a = 1'b0; per_a = 40;
    wait_valid(0, n);
    wait_valid(0, n);
    chk("pre_abort_freq", freq_a, 10);
    repeat (200) @(negedge clk);
    en_a = 1'b0;
    pulses = 0;
    repeat (600) begin
      @(negedge clk);
      if (fv_a) pulses++;
    end
    chk("abort_no_valid", pulses, 0);
    chk("abort_freq_held", freq_a, 10);
    chk("abort_overflow_held", ovf_a, 0);
    chk("abort_no_signal_held", nosig_a, 0);
    en_a = 1'b1;
    wait_valid(0, n);
    chk("reenable_latency", n, GATE + 1);
    chk("reenable_freq", freq_a, 10);

    // Reset mid-window; sig held high so the first post-reset edge is the level
    repeat (250) @(negedge clk);
    rst_a = 1'b1;
    #1;
    chk("async_reset_freq", freq_a, 0);
    chk("async_reset_valid", fv_a, 0);
    chk("async_reset_overflow", ovf_a, 0);
    chk("async_reset_no_signal", nosig_a, 0);
    man_mode_a = 1'b1; man_sig_a = 1'b1;
    repeat (5) @(negedge clk);
    rst_a = 1'b0;
    wait_valid(0, n);
    chk("post_reset_latency", n, GATE + 1);
    chk("post_reset_freq", freq_a, 1);
    chk("post_reset_no_signal", nosig_a, 0);

    // Overflow with a 4-bit counter
    en_b = 1'b1;
    wait_valid(1, n);
    chk("ovf_latency", n, GATE + 1);
    chk("ovf_freq", freq_b, 15);
    chk("ovf_flag", ovf_b, 1);
    chk("ovf_no_signal", nosig_b, 0);
    per_b = 40;
    wait_valid(1, n);
    chk("ovf_cleared_next", ovf_b, 0);
    wait_valid(1, n);
    chk("ovf_recover_freq", freq_b, 10);
    chk("ovf_recover_flag", ovf_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
